// File: rtl/image_write.sv
// Frame writer: captures VSYNC/HSYNC-framed pixel pairs into a bottom-up RGB
// byte buffer and serves registered random-access reads of that buffer.
module image_write #(
    parameter int WIDTH  = 10,   // image width in pixels, must be even
    parameter int HEIGHT = 5,
    parameter int ADDR_W = 8     // 2**ADDR_W must cover WIDTH*HEIGHT*3 bytes
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              VSYNC,
    input  logic              HSYNC,
    input  logic [7:0]        DATA_R0,
    input  logic [7:0]        DATA_G0,
    input  logic [7:0]        DATA_B0,
    input  logic [7:0]        DATA_R1,
    input  logic [7:0]        DATA_G1,
    input  logic [7:0]        DATA_B1,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              write_done,
    output logic              frame_error,
    output logic [18:0]       pair_count
);

    localparam int MEM_SIZE  = WIDTH * HEIGHT * 3;
    localparam int ROW_BYTES = WIDTH * 3;
    localparam int NUM_PAIRS = WIDTH * HEIGHT / 2;
    localparam int IDX_W     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT + 1) : 1;
    localparam int COL_W     = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             vsync_d;
    logic             vs_rise;
    logic             accept;
    logic             last_pair;
    logic             last_col;
    logic [ROW_W-1:0] row_idx;
    logic [COL_W-1:0] col_idx;
    logic [IDX_W-1:0] wr_base;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_in_range;
    logic [7:0]       mem [0:MEM_SIZE-1];

    // A new VSYNC edge wins over any coincident pixel data.
    assign vs_rise   = VSYNC & ~vsync_d;
    assign accept    = (state == RECV) & HSYNC & ~vs_rise;
    assign last_pair = (pair_count == 19'(NUM_PAIRS - 1));
    assign last_col  = (col_idx == COL_W'(WIDTH - 2));

    // Rows land bottom-up, as in a bitmap file.
    assign wr_base = IDX_W'(ROW_BYTES * (HEIGHT - 1 - int'(row_idx)) + 3 * int'(col_idx));

    assign rd_in_range = (32'(rd_addr) < 32'(MEM_SIZE));
    assign rd_idx      = IDX_W'(rd_addr);

    assign write_done = (state == DONE);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: assign the default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (vs_rise) begin
            state_next = RECV;
        end else if (accept && last_pair) begin
            state_next = DONE;
        end
    end

    always_ff @(posedge HCLK) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
        if (HRESET) begin
            vsync_d     <= 1'b0;
            row_idx     <= '0;
            col_idx     <= '0;
            pair_count  <= '0;
            frame_error <= 1'b0;
        end else begin
            vsync_d <= VSYNC;
            if (vs_rise) begin
                row_idx    <= '0;
                col_idx    <= '0;
                pair_count <= '0;
                if (state == RECV && pair_count != '0) begin
                    frame_error <= 1'b1;
                end
            end else if (accept) begin
                pair_count <= pair_count + 19'd1;
                if (last_col) begin
                    col_idx <= '0;
                    row_idx <= row_idx + ROW_W'(1);
                end else begin
                    col_idx <= col_idx + COL_W'(2);
                end
            end
        end
    end

    // NOTE: the frame buffer has no reset; its contents survive HRESET.
    always_ff @(posedge HCLK) begin
        if (!HRESET && accept) begin
            mem[wr_base]               <= DATA_R0;
            mem[wr_base + IDX_W'(1)]   <= DATA_G0;
            mem[wr_base + IDX_W'(2)]   <= DATA_B0;
            mem[wr_base + IDX_W'(3)]   <= DATA_R1;
            mem[wr_base + IDX_W'(4)]   <= DATA_G1;
            mem[wr_base + IDX_W'(5)]   <= DATA_B1;
        end
    end

    // A same-cycle write to rd_addr is not visible until the following read.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_data <= 8'h00;
        end else if (rd_in_range) begin
            rd_data <= mem[rd_idx];
        end else begin
            rd_data <= 8'h00;
        end
    end

endmodule

// File: tb/tb_image_write.sv
// Directed bench for image_write: full frames, address mapping, abort,
// ignored data outside a frame, mid-frame reset and read latency.
module tb_image_write;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic       VSYNC = 1'b0;
    logic       HSYNC = 1'b0;
    logic [7:0] DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
    logic [7:0] DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
    logic [7:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       write_done;
    logic       frame_error;
    logic [18:0] pair_count;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp_data;
    } rd_vec_t;

    rd_vec_t rd_tab [20];

    image_write #(.WIDTH(10), .HEIGHT(5), .ADDR_W(8)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .VSYNC       (VSYNC),
        .HSYNC       (HSYNC),
        .DATA_R0     (DATA_R0),
        .DATA_G0     (DATA_G0),
        .DATA_B0     (DATA_B0),
        .DATA_R1     (DATA_R1),
        .DATA_G1     (DATA_G1),
        .DATA_B1     (DATA_B1),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .write_done  (write_done),
        .frame_error (frame_error),
        .pair_count  (pair_count)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Pair 0 carries 0x11..0x66; pair p>0 carries bytes 6p..6p+5; salt XORs a frame tag in.
    function automatic logic [7:0] pix(input int p, input int k, input logic [7:0] salt);
        logic [7:0] v;
        if (p == 0) v = 8'(17 * (k + 1));
        else        v = 8'(p * 6 + k);
        return v ^ salt;
    endfunction

    task automatic set_pair(input int p, input logic [7:0] salt);
        DATA_R0 = pix(p, 0, salt);
        DATA_G0 = pix(p, 1, salt);
        DATA_B0 = pix(p, 2, salt);
        DATA_R1 = pix(p, 3, salt);
        DATA_G1 = pix(p, 4, salt);
        DATA_B1 = pix(p, 5, salt);
    endtask

    // Lines of 5 pairs, with a 2-cycle HSYNC gap before each new line.
    task automatic send_pairs(input int first, input int n, input logic [7:0] salt);
        for (int p = first; p < first + n; p++) begin
            if (p % 5 == 0 && p != 0) begin
                HSYNC = 1'b0;
                tick();
                tick();
            end
            set_pair(p, salt);
            HSYNC = 1'b1;
            tick();
        end
        HSYNC = 1'b0;
    endtask

    task automatic vs_pulse();
        VSYNC = 1'b1;
        tick();
        VSYNC = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [7:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        tick();
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic full_frame(input logic [7:0] salt, input string tag);
        send_pairs(0, 24, salt);
        check({tag, "_wd_at24"}, 32'(write_done), 32'd0);
        check({tag, "_pc_at24"}, 32'(pair_count), 32'd24);
        send_pairs(24, 1, salt);
        check({tag, "_wd_done"}, 32'(write_done), 32'd1);
        check({tag, "_pc_done"}, 32'(pair_count), 32'd25);
    endtask

    initial begin
        rd_tab = '{
            '{8'd120, 8'h11}, '{8'd121, 8'h22}, '{8'd122, 8'h33},
            '{8'd123, 8'h44}, '{8'd124, 8'h55}, '{8'd125, 8'h66},
            '{8'd126, 8'h06}, '{8'd131, 8'h0B},
            '{8'd90,  8'h1E}, '{8'd95,  8'h23},
            '{8'd72,  8'h48}, '{8'd77,  8'h4D},
            '{8'd0,   8'h78}, '{8'd5,   8'h7D},
            '{8'd144, 8'h18}, '{8'd149, 8'h1D},
            '{8'd24,  8'h90}, '{8'd29,  8'h95},
            '{8'd150, 8'h00}, '{8'd255, 8'h00}
        };

        // Reset state
        tick();
        tick();
        HRESET = 1'b0;
        check("rst_write_done", 32'(write_done), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_pair_count", 32'(pair_count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        // Data before any VSYNC edge is ignored
        send_pairs(0, 3, 8'hC3);
        tick();
        check("idle_pc", 32'(pair_count), 32'd0);
        check("idle_wd", 32'(write_done), 32'd0);

        // First full frame
        vs_pulse();
        check("f1_pc_start", 32'(pair_count), 32'd0);
        full_frame(8'h00, "f1");
        check("f1_fe", 32'(frame_error), 32'd0);

        // Address mapping readback
        for (int i = 0; i < 20; i++) begin
            read_check($sformatf("map_addr%0d", rd_tab[i].addr), rd_tab[i].addr, rd_tab[i].exp_data);
        end

        // Read latency: new address visible only after the next edge
        rd_addr = 8'd150;
        tick();
        check("lat_oob", 32'(rd_data), 32'd0);
        rd_addr = 8'd121;
        #2;
        check("lat_before_edge", 32'(rd_data), 32'd0);
        tick();
        check("lat_after_edge", 32'(rd_data), 32'h22);

        // Data after write_done is ignored
        send_pairs(0, 3, 8'hEE);
        tick();
        check("done_pc_hold", 32'(pair_count), 32'd25);
        check("done_wd_hold", 32'(write_done), 32'd1);
        read_check("done_mem120", 8'd120, 8'h11);
        read_check("done_mem24", 8'd24, 8'h90);

        // VSYNC edge from DONE is not an abort
        vs_pulse();
        check("rearm_wd", 32'(write_done), 32'd0);
        check("rearm_fe", 32'(frame_error), 32'd0);
        tick();
        // VSYNC edge in RECV with no pairs yet is not an abort either
        vs_pulse();
        check("rearm0_fe", 32'(frame_error), 32'd0);
        tick();

        // VSYNC edge with HSYNC high: data dropped, counters restart
        set_pair(0, 8'h55);
        VSYNC = 1'b1;
        HSYNC = 1'b1;
        tick();
        VSYNC = 1'b0;
        HSYNC = 1'b0;
        check("coinc_pc", 32'(pair_count), 32'd0);
        check("coinc_fe", 32'(frame_error), 32'd0);
        read_check("coinc_mem120", 8'd120, 8'h11);

        // Abort after 7 pairs, then a complete frame
        send_pairs(0, 7, 8'hAA);
        check("abort_pc7", 32'(pair_count), 32'd7);
        vs_pulse();
        check("abort_fe", 32'(frame_error), 32'd1);
        check("abort_pc", 32'(pair_count), 32'd0);
        full_frame(8'hFF, "f2");
        check("f2_fe_sticky", 32'(frame_error), 32'd1);
        read_check("f2_mem120", 8'd120, 8'hEE);
        read_check("f2_mem24", 8'd24, 8'h6F);

        // Reset after 10 pairs
        vs_pulse();
        send_pairs(0, 10, 8'h33);
        check("mrst_pc10", 32'(pair_count), 32'd10);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        check("mrst_wd", 32'(write_done), 32'd0);
        check("mrst_fe", 32'(frame_error), 32'd0);
        check("mrst_pc", 32'(pair_count), 32'd0);
        check("mrst_rd", 32'(rd_data), 32'd0);
        send_pairs(0, 3, 8'h77);
        tick();
        check("mrst_ignore_pc", 32'(pair_count), 32'd0);
        read_check("mrst_mem120", 8'd120, 8'h22);

        // Fresh frame after reset
        vs_pulse();
        full_frame(8'h00, "f3");
        check("f3_fe", 32'(frame_error), 32'd0);
        read_check("f3_mem125", 8'd125, 8'h66);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/image_write.md
IMAGE_WRITE -- requirements
Module: image_write

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning image width in pixels; it must be even.
REQ-002 SHALL have parameter HEIGHT, default 5, meaning image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning frame-buffer byte-address width; it must satisfy 2^ADDR_W >= WIDTH*HEIGHT*3.
REQ-004 SHALL have port HCLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port HRESET, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port VSYNC, input, 1 bit: frame-start indicator; a rising edge arms a new frame.
REQ-007 SHALL have port HSYNC, input, 1 bit: data-valid qualifier; one pixel pair is transferred per cycle while it is high.
REQ-008 SHALL have ports DATA_R0, DATA_G0, DATA_B0, input, 8 bits each: even-column pixel components.
REQ-009 SHALL have ports DATA_R1, DATA_G1, DATA_B1, input, 8 bits each: odd-column pixel components.
REQ-010 SHALL have port rd_addr, input, ADDR_W bits: frame-buffer read byte address.
REQ-011 SHALL have port rd_data, output, 8 bits: registered read data.
REQ-012 SHALL have port write_done, output, 1 bit: level signal, high when a full frame has been stored.
REQ-013 SHALL have port frame_error, output, 1 bit: sticky flag for an aborted frame.
REQ-014 SHALL have port pair_count, output, 19 bits: number of pairs accepted in the current frame.

Function
REQ-015 SHALL hold an internal byte memory of WIDTH*HEIGHT*3 entries.
REQ-016 SHALL implement the FSM states IDLE, RECV and DONE.
REQ-017 SHALL register VSYNC one cycle to detect its rising edge (vs_rise = VSYNC & ~VSYNC_d).
REQ-018 SHALL, on vs_rise in any state, go to RECV and clear the row index, column index and pair_count; write_done goes to 0 on the next edge.
REQ-019 SHALL, in RECV, accept a pair on every cycle with HSYNC=1; HSYNC may drop between lines for any number of cycles.
REQ-020 SHALL ignore HSYNC in IDLE and DONE: no memory writes and no counter change.
REQ-021 SHALL, for each accepted pair at row r and column c (even), write six bytes in the same cycle: byte address A = WIDTH*3*(HEIGHT-1-r) + 3*c gets R0, A+1 gets G0, A+2 gets B0, A+3 gets R1, A+4 gets G1, A+5 gets B1. This stores rows bottom-up in bitmap order, R,G,B byte order.
REQ-022 SHALL advance the column by 2 per accepted pair; at c = WIDTH-2 the column wraps to 0 and r increments.
REQ-023 SHALL increment pair_count by 1 per accepted pair.
REQ-024 SHALL, on acceptance of pair number WIDTH*HEIGHT/2, go to DONE; write_done is 1 from the following cycle.
REQ-025 SHALL hold DONE until vs_rise or reset.
REQ-026 SHALL treat a vs_rise while in RECV with pair_count != 0 as an abort: set frame_error=1 and restart reception per REQ-018.
REQ-027 SHALL clear frame_error only on reset.
REQ-028 SHALL give vs_rise priority when it coincides with HSYNC=1: that cycle's data is dropped and counters restart at 0.
REQ-029 SHALL register rd_data = mem[rd_addr] one cycle after rd_addr is presented.
REQ-030 SHALL have rd_data return 0 when rd_addr >= WIDTH*HEIGHT*3.
REQ-031 SHALL, when reading and writing the same address in the same cycle, return the old data.
REQ-032 SHALL use no combinational path from any input to any output.

Reset
REQ-033 SHALL, on HRESET=1 at a rising HCLK edge, set state=IDLE, write_done=0, frame_error=0, pair_count=0, row/column indices=0, rd_data=0 and VSYNC_d=0.
REQ-034 SHALL leave memory contents unchanged by reset.
REQ-035 SHALL, if reset occurs mid-frame, discard the remainder of the frame; the next frame requires a new vs_rise.

Verification
REQ-036 SHALL cover a full frame: WIDTH=10, HEIGHT=5, vs_rise then 25 HSYNC pairs in 5 bursts of 5 -> write_done=1 one cycle after the 25th pair, pair_count=25, frame_error=0.
REQ-037 SHALL cover address mapping: first pair {R0=0x11, G0=0x22, B0=0x33, R1=0x44, G1=0x55, B1=0x66} -> bytes 120..125 read back 0x11..0x66; last pair -> bytes 24..29.
REQ-038 SHALL cover abort: vs_rise after 7 pairs -> frame_error=1, pair_count=0 the next cycle, and a following full frame completes normally.
REQ-039 SHALL cover idle data: HSYNC pulses before any vs_rise or after write_done -> memory and pair_count unchanged.
REQ-040 SHALL cover reset mid-frame: HRESET for 1 cycle after 10 pairs -> state=IDLE, all outputs 0, and subsequent HSYNC ignored until vs_rise.
REQ-041 SHALL cover read latency: rd_addr=121 presented at cycle N -> rd_data valid at cycle N+1; rd_addr=150 -> rd_data=0.
